// File: rtl/cnt_timer_arbiter.sv
// ============================================================================
// Module   : cnt_timer_arbiter
// Brief    : Round-robin sequencer sharing one down-counter timer among
//            N_REQ requesters; pulses done to the owner when the count ends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CW    = 4,
    parameter int IW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    output logic [N_REQ-1:0]    gnt,
    output logic [IW-1:0]       owner,
    output logic                busy,
    output logic [CW-1:0]       cnt,
    output logic [N_REQ-1:0]    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW:0]      c_nreq = (IW+1)'(N_REQ);
    localparam logic [IW-1:0]    c_last = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_one  = N_REQ'(1);

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_done, w_done_nxt;

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_owner_inc;

    // Round-robin search starting at r_ptr; iterating downward lets the
    // lowest offset (closest to the pointer) overwrite any later match.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [IW:0] idx;
            idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (idx >= c_nreq) begin
                idx = idx - c_nreq;
            end
            if (req[idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = idx[IW-1:0];
            end
        end
    end

    assign w_owner_inc = (r_owner == c_last) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = RUN;
                    w_gnt_nxt   = c_one << w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = len[w_win*CW +: CW];
                    w_busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                // Cancel wins over a terminal count: no done pulse.
                if (!req[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = DONE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = c_one << r_owner;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = w_owner_inc;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign cnt   = r_cnt;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: doc/cnt_timer_arbiter.md
Name: cnt_timer_arbiter

Overview:
- Shares one CW-bit down-counter timer among N_REQ requesters.
- Each requester asks for a timed interval of len cycles. The block grants the counter round-robin, loads the requested length, and counts it down.
- When the count finishes, the block pulses done to the owner and releases the counter.
- Sits between client FSMs and the shared counter datapath, and acts as its sequencer.

Parameters:
- N_REQ, 4, number of requesters.
- CW, 4, counter width in bits.
- IW, 2, owner index width; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N_REQ  per-requester request level; held high until done, or dropped to cancel.
- len  input  N_REQ*CW  flattened lengths; requester i uses bits [i*CW +: CW].
- gnt  output  N_REQ  one-hot grant; high only for the owner while in RUN.
- owner  output  IW  index of the current or last owner.
- busy  output  1  high when state != IDLE.
- cnt  output  CW  live counter value.
- done  output  N_REQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (async, rst_n=0) clears everything immediately: state=IDLE, gnt=0, done=0, cnt=0, owner=0, busy=0, rr pointer ptr=0. This applies from any state, mid-count included; no done pulse is produced.
- FSM states: IDLE, RUN, DONE; all outputs registered.
- IDLE:
  - If req != 0, pick the winner by searching i = ptr, ptr+1, … mod N_REQ; first set bit wins.
  - Next edge: state=RUN, gnt=onehot(win), owner=win, cnt=len[win]. len is sampled only at this edge; later len changes are ignored.
  - If req == 0, stay in IDLE; cnt holds.
- RUN, owner's req still high:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: state <= DONE, gnt <= 0.
- RUN, owner's req low (cancel): state <= IDLE, gnt <= 0, cnt <= 0, ptr <= owner+1 mod N_REQ, no done pulse. Cancel takes priority over cnt==0.
- DONE:
  - done[owner]=1 for exactly this cycle; busy=1.
  - Next edge: state <= IDLE, done <= 0, ptr <= owner+1 mod N_REQ.
- Timing: req rising sampled at edge T0 gives RUN for cycles T1..T(L+1), with cnt = L, L-1, …, 0. DONE is at T(L+2). Earliest next grant takes effect at T(L+4), since IDLE lasts at least one cycle.
- len = 0: one RUN cycle with cnt=0, then DONE.
- cnt never underflows; no wrap below 0.
- Requests from non-owners during RUN/DONE are ignored (not queued); they are arbitrated at the next IDLE.
- A requester holding req through done is re-arbitrated at IDLE behind others, because ptr has advanced past it.
- Single persistent requester is re-granted every L+3 cycles.
- gnt and done are never simultaneously high; at most one bit of each is set.

Test Plan:
- Reset, then req=4'b0001, len0=3 -> gnt=0001 at T1; cnt 3,2,1,0 over T1..T4; done=0001 only at T5; busy low at T6.
- req=4'b1010 simultaneously after reset (ptr=0), len1=2, len3=1 -> requester 1 served first (done[1] pulse). Requester 3 granted at the following IDLE+1, cnt=1.
- Fairness: all four req held high, all len=0 -> grants in order 0,1,2,3,0; each done pulse 3 cycles apart.
- Cancel: req0 granted with len0=9; drop req0 when cnt=5 -> next edge gnt=0, cnt=0, state IDLE, no done pulse, ptr=1.
- len change during RUN: grant with len2=4, change len2 to 15 at cnt=3 -> countdown continues 2,1,0; done[2] at the expected cycle.
- Async reset mid-count: rst_n low at cnt=6 between clock edges -> gnt, busy, cnt, done go to 0 immediately. After release, IDLE with ptr=0; req3 high -> gnt=1000.
